// File: rtl/icache_pkg.sv
// icache shared widths and address helpers.
package icache_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    function automatic logic [ADDR_W-1:0] word_align(
        input logic [ADDR_W-1:0] a
    );
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_array.sv
// icache storage: valid bits with flash clear, tag and data arrays.
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 7,
    parameter int TAG_BITS   = 23
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [INST_W-1:0]     rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [INST_W-1:0]     wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [INST_W-1:0]   data_mem [LINES];

    always_ff @(posedge clk) begin
        if (clear) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data carry no reset; valid alone gates their use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, one word per line,
// single outstanding miss to the memory controller.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_flag,
    input  logic [ADDR_W-1:0] read_addr,
    output logic              inst_flag,
    output logic [INST_W-1:0] inst_data,
    input  logic              invalidate,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [INST_W-1:0] mem_data
);

    localparam int TAG_BITS = ADDR_W - INDEX_BITS - 2;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]            state;
    logic                  kill;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [INST_W-1:0]     rd_data;
    logic                  hit;
    logic                  wr_en;
    logic                  unused_lsb;

    assign index      = read_addr[INDEX_BITS+1:2];
    assign tag        = read_addr[ADDR_W-1:INDEX_BITS+2];
    assign unused_lsb = ^read_addr[1:0];

    assign hit = read_flag & rd_valid & (rd_tag == tag)
               & ~invalidate & ~rst;

    assign inst_flag = hit;
    assign inst_data = hit ? rd_data : '0;

    // mem_addr doubles as the latched fill index/tag.
    assign wr_en = (state == WAIT) & mem_ack & ~kill
                 & ~invalidate & ~rst;

    icache_array #(
        .INDEX_BITS(INDEX_BITS),
        .TAG_BITS  (TAG_BITS)
    ) u_array (
        .clk     (clk),
        .clear   (rst | invalidate),
        .rd_index(index),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_index(mem_addr[INDEX_BITS+1:2]),
        .wr_tag  (mem_addr[ADDR_W-1:INDEX_BITS+2]),
        .wr_data (mem_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            kill     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (read_flag & ~hit & ~invalidate) begin
                        state    <= WAIT;
                        mem_req  <= 1'b1;
                        mem_addr <= word_align(read_addr);
                        kill     <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        kill    <= 1'b0;
                    end else if (invalidate) begin
                        kill <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    kill    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: scoreboard of expected
// lookup/request values, compared as the DUT produces them.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_flag;
    logic [31:0] read_addr;
    logic        inst_flag;
    logic [31:0] inst_data;
    logic        invalidate;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    icache dut (
        .clk       (clk),
        .rst       (rst),
        .read_flag (read_flag),
        .read_addr (read_addr),
        .inst_flag (inst_flag),
        .inst_data (inst_data),
        .invalidate(invalidate),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic want(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic observe(input logic [31:0] got);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", got, 32'hxxxx_xxxx);
        end else begin
            e = exp_q.pop_front();
            chk(e.tag, got, e.val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string tag, input logic f,
                        input logic [31:0] d);
        want({tag, "_flag"}, {31'd0, f});
        want({tag, "_data"}, d);
        observe({31'd0, inst_flag});
        observe(inst_data);
    endtask

    task automatic req(input string tag, input logic r,
                       input logic [31:0] a);
        want({tag, "_req"}, {31'd0, r});
        want({tag, "_addr"}, a);
        observe({31'd0, mem_req});
        observe(mem_addr);
    endtask

    task automatic miss_fill(input string tag, input logic [31:0] a,
                             input logic [31:0] d, input int lat);
        read_flag = 1'b1;
        read_addr = a;
        @(negedge clk);
        look({tag, "_miss"}, 1'b0, 32'd0);
        step();
        @(negedge clk);
        req({tag, "_issue"}, 1'b1, {a[31:2], 2'b00});
        repeat (lat) step();
        mem_data = d;
        mem_ack  = 1'b1;
        step();
        mem_ack  = 1'b0;
        @(negedge clk);
        look({tag, "_hit"}, 1'b1, d);
        req({tag, "_done"}, 1'b0, {a[31:2], 2'b00});
    endtask

    initial begin
        rst        = 1'b1;
        read_flag  = 1'b0;
        read_addr  = '0;
        invalidate = 1'b0;
        mem_ack    = 1'b0;
        mem_data   = '0;
        step();
        step();
        @(negedge clk);
        look("reset", 1'b0, 32'd0);
        req("reset", 1'b0, 32'd0);
        step();
        rst = 1'b0;

        // Cold miss, ack three cycles after the request.
        miss_fill("cold", 32'h100, 32'h0051_0113, 3);

        // Hit with differing low bits, no new request.
        step();
        read_addr = 32'h102;
        @(negedge clk);
        look("hit102", 1'b1, 32'h0051_0113);
        step();
        @(negedge clk);
        req("hit102", 1'b0, 32'h100);

        // Conflict eviction on the same index.
        miss_fill("c300", 32'h300, 32'haaaa_0300, 1);
        step();
        miss_fill("c100", 32'h100, 32'h0051_0113, 2);

        // Redirect to a cached line while a miss is in flight.
        step();
        read_addr = 32'h400;
        @(negedge clk);
        look("r400_miss", 1'b0, 32'd0);
        step();
        @(negedge clk);
        req("r400_issue", 1'b1, 32'h400);
        read_addr = 32'h100;
        #1;
        look("r100_wait", 1'b1, 32'h0051_0113);
        step();
        mem_data = 32'h0000_0013;
        mem_ack  = 1'b1;
        step();
        mem_ack   = 1'b0;
        read_addr = 32'h400;
        @(negedge clk);
        look("r400_hit", 1'b1, 32'h0000_0013);

        // Invalidate during a miss discards the fill.
        step();
        read_addr = 32'h500;
        @(negedge clk);
        look("i500_miss", 1'b0, 32'd0);
        step();
        @(negedge clk);
        req("i500_issue", 1'b1, 32'h500);
        invalidate = 1'b1;
        read_addr  = 32'h100;
        #1;
        look("inv_force", 1'b0, 32'd0);
        step();
        invalidate = 1'b0;
        read_addr  = 32'h500;
        mem_data   = 32'hdead_beef;
        mem_ack    = 1'b1;
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        req("kill_done", 1'b0, 32'h500);
        miss_fill("i500_re", 32'h500, 32'h0000_5005, 1);
        step();
        miss_fill("i100_re", 32'h100, 32'h0051_0113, 1);

        // Reset in the middle of a miss; stray ack ignored.
        step();
        read_addr = 32'h700;
        @(negedge clk);
        look("x700_miss", 1'b0, 32'd0);
        step();
        @(negedge clk);
        req("x700_issue", 1'b1, 32'h700);
        rst       = 1'b1;
        read_flag = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        req("rst_drop", 1'b0, 32'd0);
        mem_data = 32'h1234_5678;
        mem_ack  = 1'b1;
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        req("stray_ack", 1'b0, 32'd0);
        read_flag = 1'b1;
        read_addr = 32'h100;
        #1;
        look("post_rst_100", 1'b0, 32'd0);
        read_addr = 32'h500;
        #1;
        look("post_rst_500", 1'b0, 32'd0);
        read_addr = 32'h400;
        #1;
        look("post_rst_400", 1'b0, 32'd0);
        read_flag = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
